i3c_phy_line_ctrl: RTL and testbench
====================================

// Module: i3c_phy_line_ctrl
// PURPOSE
// - Registered control stage directly upstream of the per-line OD/PP driver model; one per PHY (SCL + SDA).
// - Converts the bus controller's logical line requests (level + drive mode) into driver encoding:
//   phy_data + sel_od_pp.
// - Sequences OD<->PP mode changes so that level changes before mode.
// - Synchronises the bus lines back into the clock domain.
// - Flags SDA arbitration loss.
// PARAMETERS
// - HandoverCycles  2  cycles the new level is held in the old mode before the mode switches (1..15)
// - SyncStages      2  flip-flop stages on each bus input (>=2)
// - FilterCycles    3  stable-cycles required by the optional deglitch filter (1..7)
// PORTS
// - clk_i             in   1  core clock
// - rst_ni            in   1  asynchronous, active-low reset
// - req_valid_i       in   1  new line request present
// - req_ready_o       out  1  request accepted when valid & ready
// - req_scl_i         in   1  requested SCL logical level
// - req_sda_i         in   1  requested SDA logical level
// - req_scl_pp_i      in   1  SCL mode: 1 = push-pull, 0 = open-drain
// - req_sda_pp_i      in   1  SDA mode: 1 = push-pull, 0 = open-drain
// - scl_phy_data_o    out  1  to SCL driver phy_data_i
// - scl_sel_od_pp_o   out  1  to SCL driver sel_od_pp_i
// - sda_phy_data_o    out  1  to SDA driver phy_data_i
// - sda_sel_od_pp_o   out  1  to SDA driver sel_od_pp_i
// - bus_scl_i         in   1  raw SCL pad level
// - bus_sda_i         in   1  raw SDA pad level
// - scl_o             out  1  synchronised (optionally filtered) SCL
// - sda_o             out  1  synchronised (optionally filtered) SDA
// - arb_lost_o        out  1  one-cycle pulse on SDA arbitration loss
// BEHAVIOUR
// - Reset values:
//   - all phy_data_o = 0, all sel_od_pp_o = 0 (lines released, high-Z)
//   - req_ready_o = 1, scl_o = sda_o = 1, arb_lost_o = 0
//   - sync and filter flops preset to 1
// - Encoding, per line, from the current applied level L and mode M:
//   - M = PP: phy_data = L, sel = 1
//   - M = OD: phy_data = ~L (1 pulls low, 0 releases), sel = 0
//   - Outputs are registered, so the first driver change occurs 1 cycle after acceptance.
// - FSM states: IDLE, HANDOVER.
// - IDLE, request accepted with no mode change on either line:
//   - new levels are applied next cycle
//   - stay in IDLE; ready stays 1
// - IDLE, request accepted with a mode change on either line:
//   - the new levels are applied in the OLD modes next cycle
//   - load the counter with HandoverCycles, go to HANDOVER, ready = 0
// - HANDOVER:
//   - counter decrements each cycle
//   - at 0, the new modes are applied, return to IDLE, ready = 1 on the same edge
//   - lines with an unchanged mode are unaffected
// - While ready = 0, valid is ignored; the source holds its request stable.
// - Reset mid-HANDOVER returns both lines to released OD, with no pending switch.
// - Sync chain:
//   - scl_o and sda_o follow the bus after SyncStages cycles (more with the filter)
//   - both chains are equal length, so SCL/SDA relative order is preserved
// - Arbitration loss: arb_lost_o pulses for 1 cycle when all of the following hold:
//   - the SDA applied mode is OD, the SDA applied level is 1, sda_o = 0
//   - a rising edge of scl_o is detected (registered scl_o = 0 -> 1)
//   - it fires at most once per SCL rise
//   - no pulse while SDA is in PP or driven low
// CONFIGURATION
// - Macro I3C_PHY_GLITCH_FILTER_EN.
// - Defined:
//   - each synchronised line passes a saturating counter filter
//   - the output changes only after the input has differed from the output for FilterCycles
//     consecutive cycles
//   - a differing run shorter than FilterCycles is discarded and the counter clears
//   - added latency is FilterCycles cycles
// - Undefined: filter absent; scl_o = last sync stage; FilterCycles is unused.
// STRUCTURE
// - Package i3c_phy_pkg:
//   - typedef struct packed {logic level; logic pp;} line_req_t
//   - typedef enum logic {LcIdle, LcHandover} line_ctrl_state_e
//   - function encode_line(line_req_t) -> {phy_data, sel}
// - Sub-module i3c_phy_line_sync:
//   - synchroniser plus optional filter, with params SyncStages and FilterCycles
//   - instantiated twice (SCL, SDA)
// - Top level holds the FSM, the handover counter, the output registers and the arbitration detect.
// TESTING
// - Reset:
//   - assert rst_ni = 0 asynchronously mid-cycle
//     -> all phy_data = 0, sel = 0, ready = 1, scl_o = sda_o = 1 immediately
// - OD drive:
//   - accept sda = 0 od, scl = 1 od
//     -> next cycle sda_phy_data = 1, sda_sel = 0, scl_phy_data = 0; ready stays 1
// - Handover, HandoverCycles = 2:
//   - from SDA OD low, accept sda = 1 pp
//     -> cycle 1: sda_phy_data = 0, sel = 0, ready = 0
//     -> 2 cycles later: sel = 1, phy_data = 1, ready = 1
// - Ignore while busy:
//   - during HANDOVER, pulse valid with sda = 0 -> outputs unchanged, request not consumed
// - Sync and arbitration:
//   - SDA released OD; bus_sda = 0 then bus_scl 0 -> 1
//     -> sda_o falls 2 cycles after bus_sda
//     -> arb_lost_o is one 1-cycle pulse after the scl_o rise
//   - repeat with SDA in PP -> no pulse
// - Filter, macro defined, FilterCycles = 3:
//   - 2-cycle low glitch on bus_scl -> scl_o stays 1
//   - 4-cycle low -> scl_o falls SyncStages + 3 cycles after the input edge

Source files
------------

// File: rtl/i3c_phy_pkg.sv
// Shared types and the line-driver encoding used by the I3C PHY line controller.
package i3c_phy_pkg;

    typedef struct packed {
        logic level;
        logic pp;
    } line_req_t;

    typedef enum logic {
        LcIdle     = 1'b0,
        LcHandover = 1'b1
    } line_ctrl_state_e;

    // Returns {phy_data, sel_od_pp}; in open-drain a 1 on phy_data pulls the line low.
    function automatic logic [1:0] encode_line(input line_req_t req);
        logic [1:0] enc;
        if (req.pp) begin
            enc = {req.level, 1'b1};
        end else begin
            enc = {~req.level, 1'b0};
        end
        return enc;
    endfunction

endpackage

// File: rtl/i3c_phy_line_sync.sv
// Bus-line synchroniser with an optional saturating deglitch filter.
// Filter is built only when I3C_PHY_GLITCH_FILTER_EN is defined.
module i3c_phy_line_sync #(
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned FilterCycles = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic line_o
);

    logic [SyncStages-1:0] r_sync;

    // Synchroniser chain; the MSB is the last stage, preset high like an idle bus.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], line_i};
        end
    end

`ifdef I3C_PHY_GLITCH_FILTER_EN
    localparam logic [2:0] FiltLast = 3'(FilterCycles - 1);

    logic       r_filt_out;
    logic [2:0] r_filt_cnt;

    // Output flips only after FilterCycles consecutive differing samples; shorter runs are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_filt_out <= 1'b1;
            r_filt_cnt <= 3'd0;
        end else if (r_sync[SyncStages-1] != r_filt_out) begin
            if (r_filt_cnt == FiltLast) begin
                r_filt_out <= r_sync[SyncStages-1];
                r_filt_cnt <= 3'd0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 3'd1;
            end
        end else begin
            r_filt_cnt <= 3'd0;
        end
    end

    assign line_o = r_filt_out;
`else
    assign line_o = r_sync[SyncStages-1];
`endif

endmodule

// File: rtl/i3c_phy_line_ctrl.sv
// I3C PHY line control: level/mode requests to OD/PP driver encoding with level-before-mode
// handover, bus-line synchronisation and SDA arbitration-loss detect (filter: I3C_PHY_GLITCH_FILTER_EN).
module i3c_phy_line_ctrl
    import i3c_phy_pkg::*;
#(
    parameter int unsigned HandoverCycles = 2,
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned FilterCycles   = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_valid_i,
    output logic req_ready_o,
    input  logic req_scl_i,
    input  logic req_sda_i,
    input  logic req_scl_pp_i,
    input  logic req_sda_pp_i,
    output logic scl_phy_data_o,
    output logic scl_sel_od_pp_o,
    output logic sda_phy_data_o,
    output logic sda_sel_od_pp_o,
    input  logic bus_scl_i,
    input  logic bus_sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic arb_lost_o
);

    localparam logic [3:0] HoLoad = 4'(HandoverCycles);

    line_ctrl_state_e r_state, w_state_n;
    logic [3:0]       r_cnt, w_cnt_n;
    logic             r_ready, w_ready_n;
    line_req_t        r_scl_app, r_sda_app, w_scl_app_n, w_sda_app_n;
    logic             r_scl_pend_pp, r_sda_pend_pp, w_scl_pend_pp_n, w_sda_pend_pp_n;
    logic [1:0]       r_scl_enc, r_sda_enc;
    logic             w_scl_sync, w_sda_sync;
    logic             r_scl_prev, r_arb_lost, w_arb_lost;
    logic             w_accept, w_mode_change;

    assign w_accept      = req_valid_i & r_ready;
    assign w_mode_change = (req_scl_pp_i != r_scl_app.pp) | (req_sda_pp_i != r_sda_app.pp);

    // Next applied level/mode; on a mode change the new level goes out first in the old mode.
    always_comb begin
        w_state_n       = r_state;
        w_cnt_n         = r_cnt;
        w_ready_n       = r_ready;
        w_scl_app_n     = r_scl_app;
        w_sda_app_n     = r_sda_app;
        w_scl_pend_pp_n = r_scl_pend_pp;
        w_sda_pend_pp_n = r_sda_pend_pp;
        case (r_state)
            LcIdle: begin
                if (w_accept) begin
                    w_scl_app_n.level = req_scl_i;
                    w_sda_app_n.level = req_sda_i;
                    w_scl_pend_pp_n   = req_scl_pp_i;
                    w_sda_pend_pp_n   = req_sda_pp_i;
                    if (w_mode_change) begin
                        w_state_n = LcHandover;
                        w_cnt_n   = HoLoad;
                        w_ready_n = 1'b0;
                    end else begin
                        w_state_n = LcIdle;
                    end
                end else begin
                    w_state_n = LcIdle;
                end
            end
            LcHandover: begin
                if (r_cnt <= 4'd1) begin
                    w_scl_app_n.pp = r_scl_pend_pp;
                    w_sda_app_n.pp = r_sda_pend_pp;
                    w_state_n      = LcIdle;
                    w_cnt_n        = 4'd0;
                    w_ready_n      = 1'b1;
                end else begin
                    w_cnt_n = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_n = LcIdle;
                w_cnt_n   = 4'd0;
                w_ready_n = 1'b1;
            end
        endcase
    end

    // Control state and registered driver encoding; reset releases both lines in open-drain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= LcIdle;
            r_cnt         <= 4'd0;
            r_ready       <= 1'b1;
            r_scl_app     <= '{level: 1'b1, pp: 1'b0};
            r_sda_app     <= '{level: 1'b1, pp: 1'b0};
            r_scl_pend_pp <= 1'b0;
            r_sda_pend_pp <= 1'b0;
            r_scl_enc     <= 2'b00;
            r_sda_enc     <= 2'b00;
        end else begin
            r_state       <= w_state_n;
            r_cnt         <= w_cnt_n;
            r_ready       <= w_ready_n;
            r_scl_app     <= w_scl_app_n;
            r_sda_app     <= w_sda_app_n;
            r_scl_pend_pp <= w_scl_pend_pp_n;
            r_sda_pend_pp <= w_sda_pend_pp_n;
            r_scl_enc     <= encode_line(w_scl_app_n);
            r_sda_enc     <= encode_line(w_sda_app_n);
        end
    end

    i3c_phy_line_sync #(
        .SyncStages  (SyncStages),
        .FilterCycles(FilterCycles)
    ) u_scl_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .line_i(bus_scl_i),
        .line_o(w_scl_sync)
    );

    i3c_phy_line_sync #(
        .SyncStages  (SyncStages),
        .FilterCycles(FilterCycles)
    ) u_sda_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .line_i(bus_sda_i),
        .line_o(w_sda_sync)
    );

    // We released SDA (OD, level 1) yet see it low on an SCL rise: another device won.
    assign w_arb_lost = w_scl_sync & ~r_scl_prev & ~w_sda_sync & ~r_sda_app.pp & r_sda_app.level;

    // SCL edge history and the registered loss pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scl_prev <= 1'b1;
            r_arb_lost <= 1'b0;
        end else begin
            r_scl_prev <= w_scl_sync;
            r_arb_lost <= w_arb_lost;
        end
    end

    assign req_ready_o     = r_ready;
    assign scl_phy_data_o  = r_scl_enc[1];
    assign scl_sel_od_pp_o = r_scl_enc[0];
    assign sda_phy_data_o  = r_sda_enc[1];
    assign sda_sel_od_pp_o = r_sda_enc[0];
    assign scl_o           = w_scl_sync;
    assign sda_o           = w_sda_sync;
    assign arb_lost_o      = r_arb_lost;

endmodule

// File: tb/tb_i3c_phy_line_ctrl.sv
// Self-checking bench for i3c_phy_line_ctrl: directed scenarios plus random traffic vs a cycle-event model.
module tb_i3c_phy_line_ctrl;

    localparam int H = 2;
    localparam int S = 2;
    localparam int F = 3;

    logic clk, rst_ni;
    logic req_valid_i, req_ready_o, req_scl_i, req_sda_i, req_scl_pp_i, req_sda_pp_i;
    logic scl_phy_data_o, scl_sel_od_pp_o, sda_phy_data_o, sda_sel_od_pp_o;
    logic bus_scl_i, bus_sda_i, scl_o, sda_o, arb_lost_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int n, sw_edge;
    bit pend, p_scl_pp, p_sda_pp;
    bit m_scl_lvl, m_scl_pp, m_sda_lvl, m_sda_pp;
    bit scl_q[$], sda_q[$];
    bit e_scl_o, e_sda_o, e_scl_o_d, e_arb, e_ready;
`ifdef I3C_PHY_GLITCH_FILTER_EN
    bit f_scl, f_sda;
    int f_scl_run, f_sda_run;
`endif

    i3c_phy_line_ctrl #(
        .HandoverCycles(H),
        .SyncStages    (S),
        .FilterCycles  (F)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_scl_i      (req_scl_i),
        .req_sda_i      (req_sda_i),
        .req_scl_pp_i   (req_scl_pp_i),
        .req_sda_pp_i   (req_sda_pp_i),
        .scl_phy_data_o (scl_phy_data_o),
        .scl_sel_od_pp_o(scl_sel_od_pp_o),
        .sda_phy_data_o (sda_phy_data_o),
        .sda_sel_od_pp_o(sda_sel_od_pp_o),
        .bus_scl_i      (bus_scl_i),
        .bus_sda_i      (bus_sda_i),
        .scl_o          (scl_o),
        .sda_o          (sda_o),
        .arb_lost_o     (arb_lost_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] enc(input bit lvl, input bit pp);
        return pp ? {lvl, 1'b1} : {~lvl, 1'b0};
    endfunction

    task automatic model_reset();
        n = 0; sw_edge = 0; pend = 0;
        m_scl_lvl = 1; m_scl_pp = 0; m_sda_lvl = 1; m_sda_pp = 0;
        scl_q.delete(); sda_q.delete();
        for (int i = 0; i < S; i++) begin
            scl_q.push_back(1'b1);
            sda_q.push_back(1'b1);
        end
        e_scl_o = 1; e_sda_o = 1; e_scl_o_d = 1; e_arb = 0; e_ready = 1;
`ifdef I3C_PHY_GLITCH_FILTER_EN
        f_scl = 1; f_sda = 1; f_scl_run = 0; f_sda_run = 0;
`endif
    endtask

`ifdef I3C_PHY_GLITCH_FILTER_EN
    task automatic filt_step(input bit s, inout bit o, inout int run);
        if (s != o) begin
            run++;
            if (run == F) begin
                o = s;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endtask
`endif

    task automatic set_req(input bit v, input bit scl, input bit sda, input bit scl_pp, input bit sda_pp);
        req_valid_i = v; req_scl_i = scl; req_sda_i = sda; req_scl_pp_i = scl_pp; req_sda_pp_i = sda_pp;
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic tick();
        bit prev_scl_sync, prev_sda_sync;
        @(posedge clk);
        e_arb = e_scl_o & ~e_scl_o_d & ~e_sda_o & ~m_sda_pp & m_sda_lvl;
        e_scl_o_d = e_scl_o;
        prev_scl_sync = scl_q[0];
        prev_sda_sync = sda_q[0];
        scl_q.push_back(bus_scl_i); void'(scl_q.pop_front());
        sda_q.push_back(bus_sda_i); void'(sda_q.pop_front());
`ifdef I3C_PHY_GLITCH_FILTER_EN
        filt_step(prev_scl_sync, f_scl, f_scl_run);
        filt_step(prev_sda_sync, f_sda, f_sda_run);
        e_scl_o = f_scl;
        e_sda_o = f_sda;
`else
        e_scl_o = scl_q[0];
        e_sda_o = sda_q[0];
`endif
        n++;
        if (pend && n == sw_edge) begin
            m_scl_pp = p_scl_pp;
            m_sda_pp = p_sda_pp;
            pend = 0;
        end
        if (req_valid_i && (n - 1) >= sw_edge) begin
            m_scl_lvl = req_scl_i;
            m_sda_lvl = req_sda_i;
            if (req_scl_pp_i != m_scl_pp || req_sda_pp_i != m_sda_pp) begin
                pend = 1; p_scl_pp = req_scl_pp_i; p_sda_pp = req_sda_pp_i;
                sw_edge = n + H;
            end
        end
        e_ready = (n >= sw_edge);
        #1;
        check_val("scl_enc", {scl_phy_data_o, scl_sel_od_pp_o}, enc(m_scl_lvl, m_scl_pp));
        check_val("sda_enc", {sda_phy_data_o, sda_sel_od_pp_o}, enc(m_sda_lvl, m_sda_pp));
        check_val("ready", req_ready_o, e_ready);
        check_val("scl_o", scl_o, e_scl_o);
        check_val("sda_o", sda_o, e_sda_o);
        check_val("arb_lost", arb_lost_o, e_arb);
        prev_scl_sync = 0;
        prev_sda_sync = 0;
    endtask

    // Asynchronous reset mid-cycle; called right after tick() so no edge falls inside it.
    task automatic do_reset();
        #2 rst_ni = 0;
        #1;
        check_val("rst_scl_enc", {scl_phy_data_o, scl_sel_od_pp_o}, 2'b00);
        check_val("rst_sda_enc", {sda_phy_data_o, sda_sel_od_pp_o}, 2'b00);
        check_val("rst_ready", req_ready_o, 1'b1);
        check_val("rst_lines", {scl_o, sda_o}, 2'b11);
        check_val("rst_arb", arb_lost_o, 1'b0);
        #1 rst_ni = 1;
        model_reset();
    endtask

    task automatic run_ticks(input int cnt, output int pulses);
        pulses = 0;
        for (int i = 0; i < cnt; i++) begin
            tick();
            if (arb_lost_o === 1'b1) pulses++;
        end
    endtask

    initial begin
        int pulses;
        clk = 0; rst_ni = 0;
        set_req(0, 1, 1, 0, 0);
        bus_scl_i = 1; bus_sda_i = 1;
        @(posedge clk);
        #1 rst_ni = 1;
        do_reset();

        // Open-drain drive, no mode change
        set_req(1, 1, 0, 0, 0);
        tick();
        check_val("od_sda", {sda_phy_data_o, sda_sel_od_pp_o}, 2'b10);
        check_val("od_scl", {scl_phy_data_o, scl_sel_od_pp_o}, 2'b00);
        check_val("od_ready", req_ready_o, 1'b1);
        set_req(0, 1, 0, 0, 0);
        tick();

        // Handover SDA OD low -> PP high, with an ignored request in the middle
        set_req(1, 1, 1, 0, 1);
        tick();
        check_val("ho_c1", {sda_phy_data_o, sda_sel_od_pp_o, req_ready_o}, 3'b000);
        set_req(1, 1, 0, 0, 1);
        tick();
        check_val("ho_busy", {sda_phy_data_o, sda_sel_od_pp_o, req_ready_o}, 3'b000);
        set_req(0, 1, 0, 0, 1);
        tick();
        check_val("ho_done", {sda_phy_data_o, sda_sel_od_pp_o, req_ready_o}, 3'b111);

        // SDA back to released OD, then arbitration loss on an SCL rise
        set_req(1, 1, 1, 0, 0);
        tick();
        set_req(0, 1, 1, 0, 0);
        run_ticks(3, pulses);
        bus_scl_i = 0;
        run_ticks(6, pulses);
        bus_sda_i = 0;
`ifndef I3C_PHY_GLITCH_FILTER_EN
        tick();
        check_val("sda_sync_1", sda_o, 1'b1);
        tick();
        check_val("sda_sync_2", sda_o, 1'b0);
`endif
        run_ticks(6, pulses);
        bus_scl_i = 1;
        run_ticks(10, pulses);
        check_val("arb_pulses_od", pulses, 1);

        // Same with SDA in push-pull: no loss
        set_req(1, 1, 1, 0, 1);
        tick();
        set_req(0, 1, 1, 0, 1);
        run_ticks(3, pulses);
        bus_scl_i = 0;
        run_ticks(6, pulses);
        bus_scl_i = 1;
        run_ticks(10, pulses);
        check_val("arb_pulses_pp", pulses, 0);
        bus_sda_i = 1;
        run_ticks(8, pulses);

`ifdef I3C_PHY_GLITCH_FILTER_EN
        // Short glitch is swallowed; a long low passes after S + F cycles
        bus_scl_i = 0;
        tick(); tick();
        bus_scl_i = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val("glitch_scl", scl_o, 1'b1);
        end
        bus_scl_i = 0;
        for (int j = 1; j <= S + F; j++) begin
            if (j == 5) bus_scl_i = 1;
            tick();
            check_val("filt_fall", scl_o, (j >= S + F) ? 1'b0 : 1'b1);
        end
        run_ticks(10, pulses);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            req_valid_i = 1'($urandom_range(0, 1));
            req_scl_i   = 1'($urandom_range(0, 1));
            req_sda_i   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) req_scl_pp_i = ~req_scl_pp_i;
            if ($urandom_range(0, 3) == 0) req_sda_pp_i = ~req_sda_pp_i;
            if ($urandom_range(0, 2) == 0) bus_scl_i = ~bus_scl_i;
            if ($urandom_range(0, 2) == 0) bus_sda_i = ~bus_sda_i;
            tick();
        end

        // Reset in the middle of a handover
        set_req(0, 1, 1, 0, 0);
        run_ticks(4, pulses);
        set_req(1, 0, 0, 1, 1);
        tick();
        set_req(0, 0, 0, 1, 1);
        do_reset();
        run_ticks(5, pulses);
        check_val("post_rst_sda", {sda_phy_data_o, sda_sel_od_pp_o}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
